dram_stream_unpacker: RTL and testbench

Downstream stage of the DRAM read path: accepts the 64-bit word stream produced by the DRAM reader, buffers it in a small FIFO, and re-emits it as narrower little-endian beats with a LAST marker on the final beat of each transfer. It is configured by the same CONFIG_VALID/CONFIG_NBYTES broadcast as the reader, so both stages agree on transfer length. It decouples the AXI read channel from a slower pixel consumer.

---
 rtl/dram_stream_unpacker.sv | 187 ++++++++++++++++++
 tb/tb_dram_stream_unpacker.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_stream_unpacker.sv
// Buffers 64-bit DRAM reader words in a small FIFO and re-emits them as little-endian OUT_BYTES beats with LAST.
// Optional build macro: DRAM_UNPACK_STALL_COUNT_EN adds the STALL_CYCLES output-stall counter.
module dram_stream_unpacker #(
    parameter int OUT_BYTES  = 1,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   CONFIG_VALID,
    output logic                   CONFIG_READY,
    input  logic [31:0]            CONFIG_NBYTES,
    input  logic [63:0]            IN_DATA,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    output logic [8*OUT_BYTES-1:0] OUT_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   OUT_LAST,
`ifdef DRAM_UNPACK_STALL_COUNT_EN
    output logic [31:0]            STALL_CYCLES,
`endif
    output logic                   DEBUG_STATE
);

    localparam int BEAT_W     = 8 * OUT_BYTES;
    localparam int LANES      = 8 / OUT_BYTES;
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BYTES_LOG2 = $clog2(OUT_BYTES);
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [63:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [LANE_W-1:0]     lane_q;
    logic [31:0]           words_left_q;
    logic [31:0]           beats_left_q;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        out_fire;
    logic        run_done;
    logic        cfg_accept;
    logic        cfg_load;
    logic [63:0] head_word;
    logic [31:0] lane_shift;
    logic        unused_nbytes_lsb;

    // Transfer length only has 128-byte granularity; the low bits are deliberately ignored.
    assign unused_nbytes_lsb = ^CONFIG_NBYTES[6:0];

    // FSM: IDLE accepts configuration, RUN moves one transfer through the FIFO.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        CONFIG_READY = 1'b0;
        cfg_accept   = 1'b0;
        cfg_load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                CONFIG_READY = 1'b1;
                cfg_accept   = CONFIG_VALID;
                if (CONFIG_VALID && (CONFIG_NBYTES[31:7] != '0)) begin
                    cfg_load = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign DEBUG_STATE = (state_q == ST_RUN);

    // Handshakes: a transfer happens on a rising edge where both valid and ready are high;
    // valid never waits for ready, and IN_READY depends on registered state only.
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign IN_READY  = (state_q == ST_RUN) && !full && (words_left_q != '0);
    assign push      = IN_VALID && IN_READY;
    assign OUT_VALID = !empty;
    assign out_fire  = OUT_VALID && OUT_READY;
    assign pop       = out_fire && (lane_q == LAST_LANE);
    assign OUT_LAST  = OUT_VALID && (beats_left_q == 32'd1);
    assign run_done  = out_fire && OUT_LAST;

    assign head_word  = mem[rd_ptr_q];
    assign lane_shift = 32'(lane_q) * 32'(BEAT_W);
    // Storage is not reset, so the beat is forced to zero while nothing is buffered.
    assign OUT_DATA   = empty ? '0 : BEAT_W'(head_word >> lane_shift);

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wr_ptr_q] <= IN_DATA;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lane_q       <= '0;
            words_left_q <= '0;
            beats_left_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (cfg_load) begin
                words_left_q <= {3'b000, CONFIG_NBYTES[31:7], 4'b0000};
                beats_left_q <= {CONFIG_NBYTES[31:7], 7'b0000000} >> BYTES_LOG2;
                lane_q       <= '0;
            end else begin
                if (push) begin
                    words_left_q <= words_left_q - 32'd1;
                end
                if (out_fire) begin
                    beats_left_q <= beats_left_q - 32'd1;
                    lane_q       <= (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
                end
            end
        end
    end

`ifdef DRAM_UNPACK_STALL_COUNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            stall_q <= '0;
        end else if (cfg_accept) begin
            stall_q <= '0;
        end else if ((state_q == ST_RUN) && OUT_VALID && !OUT_READY && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign STALL_CYCLES = stall_q;
`else
    logic unused_cfg_accept;
    assign unused_cfg_accept = cfg_accept;
`endif

    // The final beat always consumes the last buffered word, so the run ends with an empty FIFO.
    a_last_drains_fifo: assert property (@(posedge ACLK) disable iff (!ARESETN)
        run_done |-> (count_q == 1) && (lane_q == LAST_LANE));

    a_idle_is_empty: assert property (@(posedge ACLK) disable iff (!ARESETN)
        (state_q == ST_IDLE) |-> empty);

    a_no_beat_underflow: assert property (@(posedge ACLK) disable iff (!ARESETN)
        out_fire |-> (beats_left_q != '0));

endmodule

// File: tb/tb_dram_stream_unpacker.sv
// Bench for dram_stream_unpacker: three instances (1, 2 and 8 byte beats) checked against a byte-queue model.
module tb_dram_stream_unpacker;

    localparam int N = 3;

    logic aclk = 1'b0;
    logic aresetn;

    logic        cfg_valid  [N];
    logic [31:0] cfg_nbytes [N];
    logic [63:0] in_data    [N];
    logic        in_valid   [N];
    logic        out_ready  [N];

    wire [N-1:0] cfg_ready;
    wire [N-1:0] in_ready;
    wire [N-1:0] out_valid;
    wire [N-1:0] out_last;
    wire [N-1:0] dbg_state;
    wire [63:0]  out_data [N];
`ifdef DRAM_UNPACK_STALL_COUNT_EN
    wire [31:0]  stall [N];
`endif

    always #5 aclk = ~aclk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int OB = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
        logic [8*OB-1:0] od;
        dram_stream_unpacker #(.OUT_BYTES(OB), .DEPTH_LOG2(4)) u_dut (
            .ACLK          (aclk),
            .ARESETN       (aresetn),
            .CONFIG_VALID  (cfg_valid[g]),
            .CONFIG_READY  (cfg_ready[g]),
            .CONFIG_NBYTES (cfg_nbytes[g]),
            .IN_DATA       (in_data[g]),
            .IN_VALID      (in_valid[g]),
            .IN_READY      (in_ready[g]),
            .OUT_DATA      (od),
            .OUT_VALID     (out_valid[g]),
            .OUT_READY     (out_ready[g]),
            .OUT_LAST      (out_last[g]),
`ifdef DRAM_UNPACK_STALL_COUNT_EN
            .STALL_CYCLES  (stall[g]),
`endif
            .DEBUG_STATE   (dbg_state[g])
        );
        assign out_data[g] = 64'(od);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int sel     = 0;

    // scoreboard: bytes the driver handed over, bytes the DUT emitted
    logic [7:0] exp_q[$];
    logic [7:0] act_q[$];
    int beats, lasts, last_idx;
    bit any_valid, last_prev;

    // model state: a byte queue plus the remaining word and beat budgets
    logic [7:0]  m_q[$];
    bit          m_run;
    logic [31:0] m_words, m_beats, m_stall;

    int          c_ob, c_words;
    logic        c_cr, c_ir, c_ov, c_ol;
    logic [63:0] c_od;

    function automatic int ob_of(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 2 : 8);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // compare process: model outputs vs DUT every cycle, then advance the model
    always @(negedge aclk) begin
        c_ob = ob_of(sel);
        if (!aresetn) begin
            m_q.delete();
            m_run   = 1'b0;
            m_words = '0;
            m_beats = '0;
            m_stall = '0;
        end
        c_words = (m_q.size() + 7) / 8;
        c_cr    = !m_run;
        c_ir    = m_run && (c_words < 16) && (m_words != 0);
        c_ov    = (m_q.size() != 0);
        c_od    = '0;
        if (c_ov) begin
            for (int b = 0; b < c_ob; b++) c_od[8*b +: 8] = m_q[b];
        end
        c_ol = c_ov && (m_beats == 1);

        check("config_ready", cfg_ready[sel], c_cr);
        check("in_ready",     in_ready[sel],  c_ir);
        check("out_valid",    out_valid[sel], c_ov);
        check("out_data",     out_data[sel],  c_od);
        check("out_last",     out_last[sel],  c_ol);
        check("debug_state",  dbg_state[sel], m_run);
`ifdef DRAM_UNPACK_STALL_COUNT_EN
        check("stall_cycles", stall[sel], m_stall);
`endif

        if (aresetn) begin
            if (out_valid[sel]) any_valid = 1'b1;
            if (last_prev) check("config_ready_after_last", cfg_ready[sel], 1'b1);
            last_prev = 1'b0;
            if (out_valid[sel] && out_ready[sel]) begin
                for (int b = 0; b < c_ob; b++) act_q.push_back(out_data[sel][8*b +: 8]);
                beats++;
                if (out_last[sel]) begin
                    lasts++;
                    last_idx  = beats;
                    last_prev = 1'b1;
                end
            end

            if (!m_run && cfg_valid[sel]) begin
                m_stall = '0;
                if (cfg_nbytes[sel][31:7] != 0) begin
                    m_run   = 1'b1;
                    m_words = 32'(cfg_nbytes[sel][31:7]) * 16;
                    m_beats = (32'(cfg_nbytes[sel][31:7]) * 128) / c_ob;
                end
            end
            if (m_run && c_ov && !out_ready[sel] && (m_stall != 32'hFFFF_FFFF)) m_stall++;
            if (c_ov && out_ready[sel]) begin
                for (int b = 0; b < c_ob; b++) void'(m_q.pop_front());
                m_beats--;
                if (c_ol) m_run = 1'b0;
            end
            if (in_valid[sel] && c_ir) begin
                for (int b = 0; b < 8; b++) m_q.push_back(in_data[sel][8*b +: 8]);
                m_words--;
            end
        end
    end

    task automatic reset_sb();
        exp_q.delete();
        act_q.delete();
        beats     = 0;
        lasts     = 0;
        last_idx  = 0;
        any_valid = 1'b0;
        last_prev = 1'b0;
    endtask

    task automatic configure(input logic [31:0] nb);
        cfg_nbytes[sel] = nb;
        cfg_valid[sel]  = 1'b1;
        @(posedge aclk);
        #1;
        cfg_valid[sel]  = 1'b0;
    endtask

    task automatic push_word(input logic [63:0] w, input int budget, output bit ok);
        bit seen;
        ok = 1'b0;
        in_data[sel]  = w;
        in_valid[sel] = 1'b1;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge aclk);
            seen = in_ready[sel];
            @(posedge aclk);
            #1;
            ok = seen;
        end
        in_valid[sel] = 1'b0;
        if (ok) begin
            for (int b = 0; b < 8; b++) exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge aclk);
            done = cfg_ready[sel];
        end
        check("idle_reached", cfg_ready[sel], 1'b1);
        @(posedge aclk);
        #1;
    endtask

    task automatic check_stream(input string name);
        int bad = 0;
        if (act_q.size() != exp_q.size()) bad++;
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            if (act_q[i] !== exp_q[i]) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        bit ok;
        int acc;
        int k;
        bit seen;

        for (int i = 0; i < N; i++) begin
            cfg_valid[i]  = 1'b0;
            cfg_nbytes[i] = '0;
            in_data[i]    = '0;
            in_valid[i]   = 1'b0;
            out_ready[i]  = 1'b0;
        end
        aresetn = 1'b0;
        reset_sb();

        // reset values
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("rst_config_ready", cfg_ready[0], 1'b1);
        check("rst_in_ready",     in_ready[0],  1'b0);
        check("rst_out_valid",    out_valid[0], 1'b0);
        check("rst_out_last",     out_last[0],  1'b0);
        check("rst_out_data",     out_data[0],  64'h0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // 1-byte beats, 128 bytes back-to-back
        sel = 0;
        reset_sb();
        out_ready[0] = 1'b1;
        configure(32'd128);
        acc = 0;
        for (int w = 0; w < 16; w++) begin
            push_word(64'h0706_0504_0302_0100 + 64'(w), 20, ok);
            if (ok) acc++;
        end
        wait_idle(300);
        check("t1_words",    acc, 16);
        check("t1_beats",    beats, 128);
        check("t1_lasts",    lasts, 1);
        check("t1_last_idx", last_idx, 128);
        if (act_q.size() >= 16) begin
            check("t1_byte0",  act_q[0],  8'h00);
            check("t1_byte7",  act_q[7],  8'h07);
            check("t1_byte8",  act_q[8],  8'h01);
            check("t1_byte15", act_q[15], 8'h07);
        end
        check_stream("t1_stream");

        // 200 bytes rounds down to 16 words; the 17th offer is refused
        reset_sb();
        configure(32'd200);
        acc = 0;
        for (int w = 0; w < 17; w++) begin
            push_word({32'hC0DE_0000 + 32'(w), 32'h1234_5600 + 32'(w)}, 30, ok);
            if (ok) acc++;
        end
        check("t2_words_accepted", acc, 16);
        check("t2_word17_refused", ok, 1'b0);
        wait_idle(300);
        check("t2_beats", beats, 128);
        check("t2_lasts", lasts, 1);
        check_stream("t2_stream");

        // 100 bytes: accepted but nothing happens
        reset_sb();
        configure(32'd100);
        repeat (20) @(posedge aclk);
        @(negedge aclk);
        check("t2_short_no_valid", any_valid, 1'b0);
        check("t2_short_idle",     cfg_ready[0], 1'b1);
        @(posedge aclk);
        #1;

        // 8-byte beats, consumer stalled for 40 cycles
        sel = 2;
        reset_sb();
        out_ready[2] = 1'b0;
        configure(32'd256);
        k = 0;
        in_valid[2] = 1'b1;
        in_data[2]  = {32'hA5A5_0000, 32'(k)};
        for (int c = 0; c < 40; c++) begin
            @(negedge aclk);
            seen = in_ready[2];
            @(posedge aclk);
            #1;
            if (seen) begin
                for (int b = 0; b < 8; b++) exp_q.push_back(in_data[2][8*b +: 8]);
                k++;
                in_data[2] = {32'hA5A5_0000, 32'(k)};
            end
        end
        in_valid[2] = 1'b0;
        check("t3_pushes_until_full", k, 16);
        @(negedge aclk);
        check("t3_in_ready_full", in_ready[2], 1'b0);
        @(posedge aclk);
        #1;
        out_ready[2] = 1'b1;
        while (k < 32) begin
            push_word({32'hA5A5_0000, 32'(k)}, 40, ok);
            if (!ok) break;
            k++;
        end
        wait_idle(200);
        check("t3_beats", beats, 32);
        check("t3_lasts", lasts, 1);
        check_stream("t3_stream");

        // 2-byte beats, random producer gaps and consumer stalls
        sel = 1;
        reset_sb();
        configure(32'd1024);
        acc = 0;
        fork
            begin
                for (int w = 0; w < 128; w++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge aclk);
                        #1;
                    end
                    push_word({$urandom(), $urandom()}, 200, ok);
                    if (ok) acc++;
                end
            end
            begin
                for (int c = 0; c < 4000 && lasts == 0; c++) begin
                    out_ready[1] = ($urandom_range(0, 3) != 0);
                    @(posedge aclk);
                    #1;
                end
                out_ready[1] = 1'b1;
            end
        join
        wait_idle(200);
        check("t4_words", acc, 128);
        check("t4_beats", beats, 512);
        check("t4_lasts", lasts, 1);
        check_stream("t4_stream");

        // reset in the middle of a transfer, then a clean one
        sel = 0;
        reset_sb();
        out_ready[0] = 1'b0;
        configure(32'd128);
        for (int w = 0; w < 5; w++) push_word(64'hDEAD_0000_0000_0000 + 64'(w), 20, ok);
        #2;
        aresetn = 1'b0;
        @(negedge aclk);
        check("t5_rst_out_valid",    out_valid[0], 1'b0);
        check("t5_rst_config_ready", cfg_ready[0], 1'b1);
        check("t5_rst_in_ready",     in_ready[0],  1'b0);
        check("t5_rst_out_last",     out_last[0],  1'b0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        reset_sb();
        out_ready[0] = 1'b1;
        configure(32'd128);
        for (int w = 0; w < 16; w++) push_word(64'h0F0E_0D0C_0B0A_0908 + 64'(w), 20, ok);
        wait_idle(300);
        check("t5_beats",    beats, 128);
        check("t5_lasts",    lasts, 1);
        check("t5_last_idx", last_idx, 128);
        check_stream("t5_stream");

`ifdef DRAM_UNPACK_STALL_COUNT_EN
        // stall counter: 10 refused cycles, held in IDLE, cleared on the next config
        reset_sb();
        out_ready[0] = 1'b0;
        configure(32'd128);
        push_word(64'h8877_6655_4433_2211, 20, ok);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge aclk);
            seen = out_valid[0];
        end
        repeat (10) @(posedge aclk);
        #1;
        out_ready[0] = 1'b1;
        @(negedge aclk);
        check("t6_stall_10", stall[0], 32'd10);
        @(posedge aclk);
        #1;
        for (int w = 1; w < 16; w++) push_word(64'h8877_6655_4433_2211 + 64'(w), 20, ok);
        wait_idle(300);
        check("t6_stall_held", stall[0], 32'd10);
        configure(32'd128);
        @(negedge aclk);
        check("t6_stall_cleared", stall[0], 32'd0);
        @(posedge aclk);
        #1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
